seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the team's hex-to-7-segment encoder: watches a multiplexed, active-low 7-segment display bus (digit enables plus segment lines) and recovers the 4-bit value shown on each digit.
- Each digit pattern is debounced over repeated scan samples, then committed to a per-digit register with blank and error flags.
- Used as a loopback monitor on display outputs and to read external scanned displays.

Parameters:
- NDIG, 4, number of multiplexed digits (1..8).
- STABLE, 4, consecutive matching samples of a digit required before commit (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset (one clock; reset is synchronous and active-low).
- an_n  in  NDIG  digit enables, active-low; bit i low = digit i is being driven.
- seg_n  in  7  segments, active-low; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- digits_o  out  4*NDIG  committed values; digit i occupies [4i+3:4i].
- blank_o  out  NDIG  committed pattern of digit i was all-off (7'h7F).
- err_o  out  NDIG  committed pattern of digit i is not a legal code.
- upd_o  out  1  one-cycle pulse when any digit commits.
- upd_idx_o  out  3  index of the digit committed with upd_o; holds its last value otherwise.
- scan_err_o  out  1  one-cycle pulse for a sample with more than one an_n bit low.

Behaviour:
- Reset (rst_n low at an edge): all outputs 0 except blank_o = all ones. Per-digit candidate registers = 7'h7F, counters = 0, commit flags = 0.
- Sample classification, evaluated every cycle:
  - All an_n high: idle, no state change.
  - More than one an_n bit low: ignored; scan_err_o pulses on the next cycle.
  - Exactly one bit d low: valid sample of digit d.
- Valid sample of digit d:
  - seg_n != cand[d]: cand[d] <= seg_n, cnt[d] <= 1, done[d] <= 0.
  - seg_n == cand[d]: cnt[d] <= min(cnt[d]+1, STABLE).
- Commit rule: a valid sample that brings cnt[d] to STABLE while done[d] = 0 (with STABLE = 1, the loading sample itself) updates, at that same edge:
  - digits_o[d], blank_o[d], err_o[d] from the decoded pattern;
  - done[d] <= 1, upd_o <= 1, upd_idx_o <= d.
- Matching samples after commit change nothing. Samples need not be contiguous in time; samples of other digits do not reset digit d's count.
- Each digit commits at most once per distinct stable pattern. Re-showing the same committed pattern after a different one restarts counting and commits again.
- Decode table (seg_n to value):
  - 01=0, 4F=1, 12=2, 06=3, 4C=4, 24=5, 20=6, 0F=7, 00=8, 04=9.
  - 7F: blank, value 0, err 0.
  - Any other pattern: err 1, value 0, blank 0.
- Only one digit can commit per cycle, so no arbitration is needed.
- Reset mid-count discards partial counts; committed values return to reset values.

Optional Feature:
- Macro SEG_SCAN_HEX_AF_EN.
- Defined: patterns 08=A, 60=b, 31=C, 42=d, 30=E, 38=F decode to 4'hA..4'hF with err 0.
- Undefined: those six patterns commit with err 1, value 0.

Decomposition:
- Package seg_pkg: localparams for the sixteen active-low patterns, SEG_BLANK = 7'h7F, segment bit-index constants, and a decode-result struct {value[3:0], blank, err}.
- One combinational sub-module, seg_pattern_decode: 7-bit pattern in, decode struct out; the macro lives only here.
- The top holds the per-digit candidate/count/done arrays and the output registers.

Test Plan:
- Reset, NDIG=4, STABLE=4: apply an_n=4'b1110, seg_n=7'h12 for 4 cycles -> upd_o pulses once after the 4th sample edge, upd_idx_o=0, digits_o[3:0]=2, err_o=0, blank_o=4'b1110.
- Round-robin scan digits 0..3 with 06, 4C, 24, 0F, 5 full rounds -> digits_o=16'h7543, exactly 4 upd_o pulses, none after.
- Digit 1 shows 20 for 3 samples, then 00 for 4 samples -> no commit for 6; one commit of 8 on the 4th 00 sample.
- Digit 2 shows 08 for 4 samples -> without the macro: err_o[2]=1, value 0. With SEG_SCAN_HEX_AF_EN: value 4'hA, err 0. Then 7F for 4 samples -> blank_o[2]=1.
- an_n=4'b1100 with seg_n=7'h01 -> scan_err_o pulses each cycle, no counter or output change. an_n=4'b1111 -> no activity.
- Digit 3 at count 3 of 01, rst_n low one cycle, then 3 more 01 samples -> no commit. A 4th sample commits 0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and types for the scanned 7-segment receive path.
// Patterns are active-low, bit6=a .. bit0=g.
package seg_pkg;

    localparam int SEG_A_BIT = 6;
    localparam int SEG_B_BIT = 5;
    localparam int SEG_C_BIT = 4;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 2;
    localparam int SEG_F_BIT = 1;
    localparam int SEG_G_BIT = 0;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'h01;
    localparam logic [6:0] SEG_1 = 7'h4F;
    localparam logic [6:0] SEG_2 = 7'h12;
    localparam logic [6:0] SEG_3 = 7'h06;
    localparam logic [6:0] SEG_4 = 7'h4C;
    localparam logic [6:0] SEG_5 = 7'h24;
    localparam logic [6:0] SEG_6 = 7'h20;
    localparam logic [6:0] SEG_7 = 7'h0F;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h04;
    localparam logic [6:0] SEG_HA = 7'h08;
    localparam logic [6:0] SEG_HB = 7'h60;
    localparam logic [6:0] SEG_HC = 7'h31;
    localparam logic [6:0] SEG_HD = 7'h42;
    localparam logic [6:0] SEG_HE = 7'h30;
    localparam logic [6:0] SEG_HF = 7'h38;

    typedef struct packed {
        logic [3:0] value;
        logic       blank;
        logic       err;
    } seg_dec_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational active-low 7-segment pattern to hex value decoder.
// Define SEG_SCAN_HEX_AF_EN to accept the A..F glyphs as legal codes.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output seg_dec_t   dec
);

    always_comb begin
        // NOTE: default every field first so no path through the case infers a latch.
        dec = '{value: 4'h0, blank: 1'b0, err: 1'b0};
        case (pattern)
            SEG_0:     dec.value = 4'h0;
            SEG_1:     dec.value = 4'h1;
            SEG_2:     dec.value = 4'h2;
            SEG_3:     dec.value = 4'h3;
            SEG_4:     dec.value = 4'h4;
            SEG_5:     dec.value = 4'h5;
            SEG_6:     dec.value = 4'h6;
            SEG_7:     dec.value = 4'h7;
            SEG_8:     dec.value = 4'h8;
            SEG_9:     dec.value = 4'h9;
            SEG_BLANK: dec.blank = 1'b1;
`ifdef SEG_SCAN_HEX_AF_EN
            SEG_HA:    dec.value = 4'hA;
            SEG_HB:    dec.value = 4'hB;
            SEG_HC:    dec.value = 4'hC;
            SEG_HD:    dec.value = 4'hD;
            SEG_HE:    dec.value = 4'hE;
            SEG_HF:    dec.value = 4'hF;
`else
`endif
            default:   dec.err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers per-digit hex values from a multiplexed active-low 7-segment bus,
// committing each digit after STABLE matching samples. Option: SEG_SCAN_HEX_AF_EN.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NDIG   = 4,
    parameter int STABLE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NDIG-1:0]     an_n,
    input  logic [6:0]          seg_n,
    output logic [4*NDIG-1:0]   digits_o,
    output logic [NDIG-1:0]     blank_o,
    output logic [NDIG-1:0]     err_o,
    output logic                upd_o,
    output logic [2:0]          upd_idx_o,
    output logic                scan_err_o
);

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [3:0] STABLE_C = 4'(STABLE);

    logic [6:0]    cand   [NDIG];
    logic [3:0]    cnt    [NDIG];
    logic          done   [NDIG];
    logic [3:0]    digit_q[NDIG];

    logic [3:0]    low_cnt;
    logic [IW-1:0] sel;
    logic          valid;
    logic          multi;
    logic          match;
    logic [3:0]    next_cnt;
    logic          commit;
    seg_dec_t      dec;

    seg_pattern_decode u_decode (
        .pattern (seg_n),
        .dec     (dec)
    );

    always_comb begin
        low_cnt = '0;
        sel     = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (!an_n[i]) begin
                low_cnt = low_cnt + 4'd1;
                sel     = IW'(i);
            end
        end
        valid = (low_cnt == 4'd1);
        multi = (low_cnt > 4'd1);
    end

    // A new pattern restarts at 1, so with STABLE=1 the loading sample commits.
    always_comb begin
        match    = (seg_n == cand[sel]);
        next_cnt = !match ? 4'd1 :
                   (cnt[sel] >= STABLE_C) ? STABLE_C : cnt[sel] + 4'd1;
        commit   = valid && (next_cnt == STABLE_C) && (!match || !done[sel]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: these per-digit arrays are tiny flop banks whose reset value is
            // functionally required (blank candidate, zero count), so they are reset.
            for (int i = 0; i < NDIG; i++) begin
                cand[i]    <= SEG_BLANK;
                cnt[i]     <= '0;
                done[i]    <= 1'b0;
                digit_q[i] <= '0;
            end
            blank_o    <= '1;
            err_o      <= '0;
            upd_o      <= 1'b0;
            upd_idx_o  <= '0;
            scan_err_o <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            upd_o      <= commit;
            scan_err_o <= multi;
            if (valid) begin
                cand[sel] <= seg_n;
                cnt[sel]  <= next_cnt;
                if (!match) begin
                    done[sel] <= 1'b0;
                end
                if (commit) begin
                    done[sel]    <= 1'b1;
                    digit_q[sel] <= dec.value;
                    blank_o[sel] <= dec.blank;
                    err_o[sel]   <= dec.err;
                    upd_idx_o    <= 3'(sel);
                end
            end
        end
    end

    for (genvar g = 0; g < NDIG; g++) begin : g_pack
        assign digits_o[4*g +: 4] = digit_q[g];
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder (NDIG=4, STABLE=4): directed scan
// vectors push expected commits; a negedge monitor pops and compares them.
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic [15:0] digits_o;
    logic [3:0]  blank_o;
    logic [3:0]  err_o;
    logic        upd_o;
    logic [2:0]  upd_idx_o;
    logic        scan_err_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  idx;
        logic [15:0] dig;
        logic [3:0]  blk;
        logic [3:0]  err;
    } exp_t;

    exp_t sb[$];
    int   scan_pending = 0;

    always #5 clk = ~clk;

    seg_scan_decoder #(.NDIG(4), .STABLE(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .digits_o   (digits_o),
        .blank_o    (blank_o),
        .err_o      (err_o),
        .upd_o      (upd_o),
        .upd_idx_o  (upd_idx_o),
        .scan_err_o (scan_err_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sample(input logic [3:0] an, input logic [6:0] seg);
        an_n  = an;
        seg_n = seg;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_upd(input logic [2:0] idx, input logic [15:0] dig,
                              input logic [3:0] blk, input logic [3:0] err);
        exp_t e;
        e.idx = idx; e.dig = dig; e.blk = blk; e.err = err;
        sb.push_back(e);
    endtask

    task automatic repeat_sample(input int n, input logic [3:0] an, input logic [6:0] seg);
        for (int k = 0; k < n; k++) sample(an, seg);
    endtask

    always @(negedge clk) begin
        if (upd_o) begin
            if (sb.size() == 0) begin
                check("upd_unexpected", 32'(upd_o), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("upd_idx", 32'(upd_idx_o), 32'(e.idx));
                check("digits",  32'(digits_o),  32'(e.dig));
                check("blank",   32'(blank_o),   32'(e.blk));
                check("err",     32'(err_o),     32'(e.err));
            end
        end
        if (scan_err_o) begin
            if (scan_pending == 0) check("scan_err_unexpected", 32'(scan_err_o), 32'd0);
            else scan_pending--;
        end
    end

    initial begin
        logic [6:0] rr_pat [4];
        logic [15:0] rr_dig [4];
        logic [3:0]  rr_blk [4];
        rr_pat = '{7'h06, 7'h4C, 7'h24, 7'h0F};
        rr_dig = '{16'h0003, 16'h0043, 16'h0543, 16'h7543};
        rr_blk = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};

        rst_n = 1'b0;
        repeat_sample(2, 4'hF, 7'h7F);
        rst_n = 1'b1;
        check("rst_digits", 32'(digits_o), 32'h0);
        check("rst_blank", 32'(blank_o), 32'hF);
        check("rst_err", 32'(err_o), 32'h0);
        check("rst_upd", 32'(upd_o), 32'h0);
        check("rst_idx", 32'(upd_idx_o), 32'h0);
        check("rst_scan_err", 32'(scan_err_o), 32'h0);

        // Digit 0 shows "2" for four samples.
        repeat_sample(4, 4'b1110, 7'h12);
        expect_upd(3'd0, 16'h0002, 4'b1110, 4'b0000);

        // Round-robin 3,4,5,7 for five rounds; commits only in round four.
        for (int r = 0; r < 5; r++) begin
            for (int d = 0; d < 4; d++) begin
                sample(~(4'b0001 << d), rr_pat[d]);
                if (r == 3) expect_upd(3'(d), rr_dig[d], rr_blk[d], 4'b0000);
            end
        end

        // Digit 1: three "6" samples then four "8" samples.
        repeat_sample(3, 4'b1101, 7'h20);
        repeat_sample(4, 4'b1101, 7'h00);
        expect_upd(3'd1, 16'h7583, 4'b0000, 4'b0000);

        // Digit 2: hex "A" glyph, then blank.
        repeat_sample(4, 4'b1011, 7'h08);
`ifdef SEG_SCAN_HEX_AF_EN
        expect_upd(3'd2, 16'h7A83, 4'b0000, 4'b0000);
`else
        expect_upd(3'd2, 16'h7083, 4'b0000, 4'b0100);
`endif
        repeat_sample(4, 4'b1011, 7'h7F);
        expect_upd(3'd2, 16'h7083, 4'b0100, 4'b0000);

        // Two digits enabled at once: ignored, scan_err each cycle.
        for (int k = 0; k < 3; k++) begin
            sample(4'b1100, 7'h01);
            scan_pending++;
        end
        repeat_sample(3, 4'b1111, 7'h01);
        check("idle_digits", 32'(digits_o), 32'h7083);
        check("idle_idx", 32'(upd_idx_o), 32'd2);

        // Digit 3 partial count, reset discards it.
        repeat_sample(3, 4'b0111, 7'h01);
        rst_n = 1'b0;
        sample(4'hF, 7'h7F);
        rst_n = 1'b1;
        check("rst2_digits", 32'(digits_o), 32'h0);
        check("rst2_blank", 32'(blank_o), 32'hF);
        check("rst2_err", 32'(err_o), 32'h0);
        repeat_sample(3, 4'b0111, 7'h01);
        sample(4'b0111, 7'h01);
        expect_upd(3'd3, 16'h0000, 4'b0111, 4'b0000);

        repeat_sample(3, 4'hF, 7'h7F);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("scan_drained", 32'(scan_pending), 32'd0);
        check("final_idx", 32'(upd_idx_o), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
